mux8_rr_arbiter: RTL and testbench



---
 rtl/mux8_rr_arbiter.sv | 93 +++++++++
 tb/tb_mux8_rr_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for the 8-channel mux datapath: grants one requester, captures
// its word into the output register and hands it downstream over valid/ready.
module mux8_rr_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        req,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  input  logic [DATA_W-1:0] in4,
  input  logic [DATA_W-1:0] in5,
  input  logic [DATA_W-1:0] in6,
  input  logic [DATA_W-1:0] in7,
  output logic [2:0]        sel,
  output logic [7:0]        grant,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        ack
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]        state;
  logic [2:0]        ptr;
  logic [DATA_W-1:0] chan [8];
  logic              xfer;
  logic [7:0]        eligible;
  logic              win_found;
  logic [2:0]        win;
  logic              load;

  assign chan[0] = in0;
  assign chan[1] = in1;
  assign chan[2] = in2;
  assign chan[3] = in3;
  assign chan[4] = in4;
  assign chan[5] = in5;
  assign chan[6] = in6;
  assign chan[7] = in7;

  assign out_valid = (state == BUSY);

  // A handshake coinciding with reset is discarded, so it must not be acknowledged.
  assign xfer = out_valid & out_ready & ~rst;
  assign ack  = grant & {8{xfer}};

  // Masking the acknowledged channel keeps it from being regranted back-to-back.
  assign eligible = req & ~ack;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    logic [2:0] idx;
    win_found = 1'b0;
    win       = ptr;
    idx       = '0;
    // Scanning from the farthest offset down leaves the nearest eligible channel as winner.
    for (int i = 7; i >= 0; i--) begin
      idx = ptr + 3'(i);
      if (eligible[idx]) begin
        win_found = 1'b1;
        win       = idx;
      end
    end
  end

  assign load = win_found & ((state == IDLE) | xfer);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      sel   <= '0;
      grant <= '0;
      out   <= '0;
    end else if (load) begin
      state <= BUSY;
      ptr   <= win + 3'd1;
      sel   <= win;
      grant <= 8'(1) << win;
      out   <= chan[win];
    end else if (xfer) begin
      state <= IDLE;
      grant <= '0;
    end
  end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: expected transfers are queued when stimulus
// is driven and compared by a monitor whenever the DUT completes a handshake.
module tb_mux8_rr_arbiter;

  typedef struct {
    logic [2:0] ch;
    logic [7:0] data;
  } xfer_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] in0, in1, in2, in3, in4, in5, in6, in7;
  logic [2:0] sel;
  logic [7:0] grant;
  logic [7:0] out;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] ack;

  int    checks = 0;
  int    errors = 0;
  bit    started = 1'b0;
  xfer_t sb_q[$];

  mux8_rr_arbiter #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst), .req(req),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .in4(in4), .in5(in5), .in6(in6), .in7(in7),
    .sel(sel), .grant(grant), .out(out), .out_valid(out_valid),
    .out_ready(out_ready), .ack(ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input logic [7:0] data);
    xfer_t e;
    e.ch   = 3'(ch);
    e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("sb_drain", 32'(sb_q.size()), 32'd0);
  endtask

  // Monitor: sample mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      if (out_valid && out_ready && !rst) begin
        if (sb_q.size() == 0) begin
          check("unexpected_xfer", {29'd0, sel}, 32'hFFFF_FFFF);
        end else begin
          xfer_t e;
          e = sb_q.pop_front();
          check("xfer_sel",   {29'd0, sel},   {29'd0, e.ch});
          check("xfer_grant", {24'd0, grant}, 32'(8'(1) << e.ch));
          check("xfer_out",   {24'd0, out},   {24'd0, e.data});
          check("xfer_ack",   {24'd0, ack},   32'(8'(1) << e.ch));
        end
      end else begin
        check("ack_quiet", {24'd0, ack}, 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = 8'hFF; out_ready = 1'b1;
    {in0, in1, in2, in3, in4, in5, in6, in7} = '0;

    // Reset held for two cycles with every channel requesting.
    tick(); started = 1'b1;
    tick();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_grant", {24'd0, grant}, 32'd0);
    check("rst_sel",   {29'd0, sel}, 32'd0);
    check("rst_out",   {24'd0, out}, 32'd0);
    check("rst_ack",   {24'd0, ack}, 32'd0);
    rst = 1'b0; req = 8'h00;
    tick();
    check("idle_valid", {31'd0, out_valid}, 32'd0);

    // Single request on channel 5, then back to IDLE with sel/out retained.
    req = 8'h20; in5 = 8'hA5; push(5, 8'hA5);
    tick();
    check("single_valid", {31'd0, out_valid}, 32'd1);
    req = 8'h00;
    tick();
    check("single_idle_valid", {31'd0, out_valid}, 32'd0);
    check("single_idle_grant", {24'd0, grant}, 32'd0);
    check("single_keep_sel",   {29'd0, sel}, 32'd5);
    check("single_keep_out",   {24'd0, out}, 32'hA5);
    drain(4);

    // Full contention from ptr=0: one word per cycle, 0..7 then 0 again.
    rst = 1'b1; tick(); rst = 1'b0;
    in0 = 8'h10; in1 = 8'h11; in2 = 8'h12; in3 = 8'h13;
    in4 = 8'h14; in5 = 8'h15; in6 = 8'h16; in7 = 8'h17;
    for (int i = 0; i < 9; i++) push(i % 8, 8'(8'h10 + (i % 8)));
    req = 8'hFF;
    for (int i = 0; i < 9; i++) tick();
    req = 8'h00;
    drain(4);
    tick();
    check("contention_idle", {31'd0, out_valid}, 32'd0);

    // Backpressure on channel 3: captured word and grant hold while input changes.
    out_ready = 1'b0; req = 8'h08; in3 = 8'h33;
    tick();
    in3 = 8'hCC;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_out",   {24'd0, out}, 32'h33);
      check("bp_grant", {24'd0, grant}, 32'h08);
      check("bp_ack",   {24'd0, ack}, 32'd0);
    end
    push(3, 8'h33); out_ready = 1'b1;
    #1 check("bp_release_ack", {24'd0, ack}, 32'h08);
    tick();
    req = 8'h00;
    drain(4);
    tick();

    // Wrap-around: grant channel 6 (ptr becomes 7), then req 8'h84 -> 7 before 2.
    req = 8'h40; in6 = 8'h66; push(6, 8'h66);
    tick();
    req = 8'h00;
    tick();
    in7 = 8'h77; in2 = 8'h22;
    push(7, 8'h77); push(2, 8'h22);
    req = 8'h84;
    tick();
    check("wrap_first_sel", {29'd0, sel}, 32'd7);
    req = 8'h04;
    tick();
    check("wrap_second_sel", {29'd0, sel}, 32'd2);
    req = 8'h00;
    drain(4);
    tick();

    // Reset while channel 4 holds a word and a handshake is pending.
    out_ready = 1'b0; req = 8'h10; in4 = 8'h44;
    tick();
    check("mid_valid", {31'd0, out_valid}, 32'd1);
    check("mid_sel",   {29'd0, sel}, 32'd4);
    rst = 1'b1; out_ready = 1'b1;
    #1 check("mid_rst_ack", {24'd0, ack}, 32'd0);
    tick();
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_grant", {24'd0, grant}, 32'd0);
    check("mid_rst_sel",   {29'd0, sel}, 32'd0);
    check("mid_rst_out",   {24'd0, out}, 32'd0);
    rst = 1'b0; in0 = 8'hA0; in4 = 8'hB4;
    push(0, 8'hA0); push(4, 8'hB4);
    req = 8'h11;
    tick();
    req = 8'h10;
    tick();
    req = 8'h00;
    drain(4);
    tick();
    check("final_idle", {31'd0, out_valid}, 32'd0);

    started = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
